// File: rtl/stopwatch_timekeeper.sv
// Stopwatch time base: packed BCD MM.SS with run/pause/clear control and a manual SET mode.
// Latency: every button and one-second tick effect shows on the registered outputs 1 clk after the causing edge.
// Backpressure: none; buttons are single-cycle pulses and only the highest-priority one acts.
module stopwatch_timekeeper #(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int MAX_MINUTES                 = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_set,
    input  logic        btn_inc,
    input  logic        btn_field,
    output logic [15:0] number,
    output logic        set_mode,
    output logic        set_field,
    output logic        running
);

    localparam int PW = (BOARD_CLOCK_FREQUENCY_IN_HZ > 1) ? $clog2(BOARD_CLOCK_FREQUENCY_IN_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(BOARD_CLOCK_FREQUENCY_IN_HZ - 1);
    localparam logic [7:0]    MAX_BCD   = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10)};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_SET     = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0]   number_nxt;
    logic          set_field_nxt;
    logic          tick;
    logic [8:0]    sec_step;
    logic [7:0]    min_step;

    // {wrapped past 59, next seconds}
    function automatic logic [8:0] sec_inc(input logic [7:0] s);
        if (s[3:0] == 4'd9) begin
            if (s[7:4] == 4'd5)
                return 9'h100;
            return {1'b0, s[7:4] + 4'd1, 4'd0};
        end
        return {1'b0, s[7:4], s[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == MAX_BCD)
            return 8'h00;
        if (m[3:0] == 4'd9)
            return {m[7:4] + 4'd1, 4'd0};
        return {m[7:4], m[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        number_nxt    = number;
        set_field_nxt = set_field;
        sec_step      = sec_inc(number[7:0]);
        min_step      = min_inc(number[15:8]);
        tick          = (state == ST_RUNNING) && (presc == PRESC_MAX);

        if (state == ST_RUNNING)
            presc_nxt = tick ? '0 : presc + PW'(1);

        if (tick) begin
            number_nxt[7:0] = sec_step[7:0];
            if (sec_step[8])
                number_nxt[15:8] = min_step;
        end

        // Tick is applied first so a coincident button can override or pause on top of it.
        if (btn_clear) begin
            state_nxt     = ST_IDLE;
            number_nxt    = 16'h0000;
            presc_nxt     = '0;
            set_field_nxt = 1'b0;
        end else if (btn_set) begin
            case (state)
                ST_IDLE, ST_PAUSED: begin
                    state_nxt     = ST_SET;
                    set_field_nxt = 1'b0;
                end
                ST_SET: begin
                    state_nxt = ST_PAUSED;
                    presc_nxt = '0;
                end
                default: ;
            endcase
        end else if (btn_start) begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_RUNNING;
                    presc_nxt = '0;
                end
                ST_PAUSED:  state_nxt = ST_RUNNING;
                ST_RUNNING: state_nxt = ST_PAUSED;
                default: ;
            endcase
        end else if (btn_field) begin
            if (state == ST_SET)
                set_field_nxt = ~set_field;
        end else if (btn_inc) begin
            if (state == ST_SET) begin
                if (set_field)
                    number_nxt[15:8] = min_step;
                else
                    number_nxt[7:0] = sec_step[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            presc     <= '0;
            number    <= 16'h0000;
            set_field <= 1'b0;
            set_mode  <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            number    <= number_nxt;
            set_field <= set_field_nxt;
            set_mode  <= (state_nxt == ST_SET);
            running   <= (state_nxt == ST_RUNNING);
        end
    end

endmodule
